// File: rtl/weighted_sum_pkg.sv
// Shared widths, limits and state encoding for the weighted-sum splitter.
// S = 2a + b + 2c + d, so the largest representable sum is 6 * NIBBLE_MAX.
package weighted_sum_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int SUM_W      = 8;
  localparam int NIBBLE_MAX = (1 << NIBBLE_W) - 1;
  localparam int MAX_SUM    = 6 * NIBBLE_MAX;

  localparam logic [SUM_W-1:0]    NIBBLE_MAX_S = SUM_W'(NIBBLE_MAX);
  localparam logic [SUM_W-1:0]    MAX_SUM_S    = SUM_W'(MAX_SUM);
  localparam logic [NIBBLE_W-1:0] NIBBLE_MAX_N = NIBBLE_W'(NIBBLE_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC_A = 3'd1,
    CALC_C = 3'd2,
    CALC_B = 3'd3,
    CALC_D = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/nibble_take.sv
// Greedy extraction of one operand from the remaining sum.
// shift=1 handles weight-2 operands (a, c); shift=0 handles weight-1 operands (b, d).
module nibble_take
  import weighted_sum_pkg::*;
(
  input  logic [SUM_W-1:0]    rem,
  input  logic                shift,
  output logic [NIBBLE_W-1:0] take,
  output logic [SUM_W-1:0]    rem_next
);

  logic [SUM_W-1:0] scaled;
  logic [SUM_W-1:0] take_ext;
  logic [SUM_W-1:0] weighted;

  always_comb begin
    scaled   = shift ? (rem >> 1) : rem;
    take     = (scaled > NIBBLE_MAX_S) ? NIBBLE_MAX_N : scaled[NIBBLE_W-1:0];
    take_ext = SUM_W'(take);
    weighted = shift ? {take_ext[SUM_W-2:0], 1'b0} : take_ext;
    // weighted <= rem by construction of take, so this never wraps
    rem_next = rem - weighted;
  end

endmodule

// File: rtl/weighted_sum_splitter.sv
// Splits an 8-bit sum S into nibbles a, b, c, d with 2a + b + 2c + d == S.
// Operands are extracted greedily in the order a, c, b, d; out-of-range S reports o_err.
//
// state  | meaning
// IDLE   | waiting for a sum, o_ready high
// CALC_A | extract a (weight 2) from rem
// CALC_C | extract c (weight 2) from rem
// CALC_B | extract b (weight 1) from rem
// CALC_D | remainder becomes d
// DONE   | result presented, held until i_ready
module weighted_sum_splitter
  import weighted_sum_pkg::*;
(
  input  logic                clk,
  input  logic                clr_n,
  input  logic [SUM_W-1:0]    i_sum,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [NIBBLE_W-1:0] o_a,
  output logic [NIBBLE_W-1:0] o_b,
  output logic [NIBBLE_W-1:0] o_c,
  output logic [NIBBLE_W-1:0] o_d,
  output logic                o_err,
  output logic                o_valid,
  input  logic                i_ready
);

  state_t              state_q;
  state_t              state_d;
  logic [SUM_W-1:0]    rem_q;
  logic [NIBBLE_W-1:0] take;
  logic [SUM_W-1:0]    rem_next;
  logic                shift;
  logic                accept;
  logic                legal;

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign accept  = i_valid && o_ready;
  assign legal   = (i_sum <= MAX_SUM_S);
  assign shift   = (state_q == CALC_A) || (state_q == CALC_C);

  nibble_take u_take (
    .rem      (rem_q),
    .shift    (shift),
    .take     (take),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = legal ? CALC_A : DONE;
      CALC_A:  state_d = CALC_C;
      CALC_C:  state_d = CALC_B;
      CALC_B:  state_d = CALC_D;
      CALC_D:  state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rem_q <= '0;
      o_a   <= '0;
      o_b   <= '0;
      o_c   <= '0;
      o_d   <= '0;
      o_err <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (legal) begin
              rem_q <= i_sum;
              o_err <= 1'b0;
            end else begin
              o_a   <= '0;
              o_b   <= '0;
              o_c   <= '0;
              o_d   <= '0;
              o_err <= 1'b1;
            end
          end
        end
        CALC_A: begin
          o_a   <= take;
          rem_q <= rem_next;
        end
        CALC_C: begin
          o_c   <= take;
          rem_q <= rem_next;
        end
        CALC_B: begin
          o_b   <= take;
          rem_q <= rem_next;
        end
        CALC_D: begin
          o_d   <= take;
          rem_q <= rem_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_sum_splitter.sv
// Directed and sweep checks for the weighted-sum splitter.
module tb_weighted_sum_splitter;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] i_sum;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] o_a, o_b, o_c, o_d;
  logic       o_err;
  logic       o_valid;
  logic       i_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  weighted_sum_splitter dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .i_sum   (i_sum),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_c     (o_c),
    .o_d     (o_d),
    .o_err   (o_err),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  typedef struct {
    int s;
    int a;
    int b;
    int c;
    int d;
    int err;
    int hold;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer s, wait for the result, hold it under backpressure, then hand off
  // while a new sum is being offered (it must not be taken on the handoff edge).
  task automatic run(input int s, input int hold,
                     output int a, output int b, output int c, output int d,
                     output int err, output int lat);
    int waitc;
    waitc = 0;
    while (!o_ready && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    check("ready_before_accept", int'(o_ready), 1);
    i_sum   = s[7:0];
    i_valid = 1'b1;
    i_ready = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_sum   = ~s[7:0];
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    a = int'(o_a); b = int'(o_b); c = int'(o_c); d = int'(o_d); err = int'(o_err);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", int'(o_valid), 1);
      check("hold_ready", int'(o_ready), 0);
      check("hold_ops", {o_a, o_b, o_c, o_d, o_err}, {a[3:0], b[3:0], c[3:0], d[3:0], err[0]});
    end
    i_sum   = 8'd5;
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("valid_after_handoff", int'(o_valid), 0);
    check("ready_after_handoff", int'(o_ready), 1);
  endtask

  initial begin
    int a, b, c, d, err, lat;

    vt[0]  = '{s:0,   a:0,  b:0,  c:0,  d:0,  err:0, hold:0};
    vt[1]  = '{s:90,  a:15, b:15, c:15, d:15, err:0, hold:0};
    vt[2]  = '{s:37,  a:15, b:1,  c:3,  d:0,  err:0, hold:1};
    vt[3]  = '{s:91,  a:0,  b:0,  c:0,  d:0,  err:1, hold:0};
    vt[4]  = '{s:255, a:0,  b:0,  c:0,  d:0,  err:1, hold:2};
    vt[5]  = '{s:89,  a:15, b:15, c:15, d:14, err:0, hold:10};
    vt[6]  = '{s:1,   a:0,  b:1,  c:0,  d:0,  err:0, hold:0};
    vt[7]  = '{s:2,   a:1,  b:0,  c:0,  d:0,  err:0, hold:0};
    vt[8]  = '{s:30,  a:15, b:0,  c:0,  d:0,  err:0, hold:0};
    vt[9]  = '{s:31,  a:15, b:1,  c:0,  d:0,  err:0, hold:3};
    vt[10] = '{s:61,  a:15, b:1,  c:15, d:0,  err:0, hold:0};
    vt[11] = '{s:50,  a:15, b:0,  c:10, d:0,  err:0, hold:0};

    clr_n   = 1'b0;
    i_sum   = 8'd0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr_n = 1'b1;
    #1;
    check("reset_ready", int'(o_ready), 1);
    check("reset_valid", int'(o_valid), 0);
    check("reset_ops", {o_a, o_b, o_c, o_d}, 0);
    check("reset_err", int'(o_err), 0);

    foreach (vt[i]) begin
      run(vt[i].s, vt[i].hold, a, b, c, d, err, lat);
      check($sformatf("lat_s%0d", vt[i].s), lat, vt[i].err ? 1 : 5);
      check($sformatf("a_s%0d", vt[i].s), a, vt[i].a);
      check($sformatf("b_s%0d", vt[i].s), b, vt[i].b);
      check($sformatf("c_s%0d", vt[i].s), c, vt[i].c);
      check($sformatf("d_s%0d", vt[i].s), d, vt[i].d);
      check($sformatf("err_s%0d", vt[i].s), err, vt[i].err);
    end

    // Reset while in CALC_B of S=50: a is already 15, so a cleared output proves the abort.
    i_sum   = 8'd50;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_abort_a", int'(o_a), 15);
    clr_n = 1'b0;
    #1;
    check("abort_valid", int'(o_valid), 0);
    check("abort_ops", {o_a, o_b, o_c, o_d}, 0);
    check("abort_err", int'(o_err), 0);
    check("abort_ready", int'(o_ready), 1);
    @(posedge clk); #1;
    clr_n = 1'b1;
    run(3, 0, a, b, c, d, err, lat);
    check("post_abort_lat", lat, 5);
    check("post_abort_ops", {a[3:0], b[3:0], c[3:0], d[3:0], err[0]},
          {4'd1, 4'd1, 4'd0, 4'd0, 1'b0});

    for (int s = 0; s < 256; s++) begin
      run(s, int'($urandom_range(0, 2)), a, b, c, d, err, lat);
      if (s <= 90) begin
        check($sformatf("sweep_err_s%0d", s), err, 0);
        check($sformatf("sweep_sum_s%0d", s), 2*a + b + 2*c + d, s);
        check($sformatf("sweep_lat_s%0d", s), lat, 5);
      end else begin
        check($sformatf("sweep_err_s%0d", s), err, 1);
        check($sformatf("sweep_zero_s%0d", s), a + b + c + d, 0);
        check($sformatf("sweep_lat_s%0d", s), lat, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/weighted_sum_splitter.md
Name: weighted_sum_splitter

Overview:
- Inverse-direction companion to the team's nibble weighted-sum datapath, which computes S = 2a + b + 2c + d from four 4-bit operands.
- Accepts one 8-bit sum S through a valid/ready handshake. Sequentially decomposes S into four nibbles (a, b, c, d) whose weighted sum reproduces S exactly.
- Used to generate legal operand sets for the summing pipeline and for round-trip self-test.
- Multi-cycle FSM with input and output handshakes and output holding under backpressure.

Parameters:
- NIBBLE_W, 4, width of each operand.
- SUM_W, 8, width of sum input; must satisfy 2^SUM_W > MAX_SUM.
- MAX_SUM, 6*(2^NIBBLE_W-1) = 90, largest representable weighted sum.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- i_sum  in  SUM_W  target sum S.
- i_valid  in  1  S valid.
- o_ready  out  1  block can accept S.
- o_a  out  NIBBLE_W  operand a (weight 2).
- o_b  out  NIBBLE_W  operand b (weight 1).
- o_c  out  NIBBLE_W  operand c (weight 2).
- o_d  out  NIBBLE_W  operand d (weight 1).
- o_err  out  1  S exceeded MAX_SUM; operands are zero.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.

Behaviour:
- Reset (clr_n low, async): state=IDLE; rem=0; o_a/o_b/o_c/o_d=0; o_err=0; o_valid=0; o_ready=1 after release.
- Reset mid-operation aborts immediately. No partial result is ever presented.
- States: IDLE, CALC_A, CALC_C, CALC_B, CALC_D, DONE. All outputs are registered.
- o_ready = (state==IDLE).
- o_valid = (state==DONE).
- IDLE, accept (i_valid & o_ready) at edge T:
  - If S <= MAX_SUM: rem<=S, o_err<=0, go to CALC_A.
  - Else: operands<=0, o_err<=1, go to DONE (o_valid high after T).
- CALC_A: a = min(15, rem>>1); rem -= 2a; go to CALC_C.
- CALC_C: c = min(15, rem>>1); rem -= 2c; go to CALC_B.
- CALC_B: b = min(15, rem); rem -= b; go to CALC_D.
- CALC_D: d = rem (guaranteed <=15 when S<=MAX_SUM); go to DONE.
- Latency: legal S gives o_valid high after edge T+4 (4 cycles); illegal S gives o_valid after T (1 cycle).
- DONE: outputs and o_err held stable while i_ready=0, for unlimited cycles. On o_valid & i_ready, go to IDLE and keep operands (don't-care until next DONE).
- No acceptance in the same cycle as output handoff; throughput is at most one sum per 6 cycles.
- i_sum is sampled only on accept; later changes are ignored.
- rem width is SUM_W, unsigned. Subtractions never underflow by construction.
- Invariant in DONE with o_err=0: 2*o_a + o_b + 2*o_c + o_d == accepted S.

Decomposition:
- Package weighted_sum_pkg: NIBBLE_W, SUM_W, MAX_SUM, NIBBLE_MAX=2^NIBBLE_W-1, state enum encoding.
- One optional sub-module, nibble_take: combinational; inputs rem and a shift flag; outputs take=min(NIBBLE_MAX, rem>>shift) and rem_next. It is reused by all four CALC states through a state-selected shift (1 for A/C, 0 for B/D).

Test Plan:
- Reset then S=0, i_ready=1 -> o_valid 4 cycles after accept; a=b=c=d=0, o_err=0.
- S=90 -> a=15, c=15, b=15, d=15, o_err=0.
- S=37 -> a=15, c=3, b=1, d=0; weighted sum 37 verified.
- S=91 and S=255 -> o_valid 1 cycle after accept; o_err=1, all operands 0.
- S=89 with i_ready low for 10 cycles -> a=15, c=15, b=15, d=14 held stable, o_ready=0 throughout; handoff on i_ready=1, o_ready=1 next cycle.
- Assert clr_n low during CALC_B of S=50 -> o_valid=0 and outputs=0 immediately. After release, S=3 -> a=1, c=0, b=1, d=0.
- Exhaustive sweep S=0..255 with random i_ready -> invariant holds for S<=90; o_err=1 for S>90.
